sort_seq: RTL and testbench
===========================

SORT_SEQ -- requirements
Module: sort_seq

Interface
REQ-001 SHALL have parameter NUM_VALS, default 8, number of elements per vector (legal range 2..64).
REQ-002 SHALL have parameter WIDTH, default 4, unsigned bits per element (legal range 1..32).
REQ-003 SHALL define derived width CW = $clog2(NUM_VALS*(NUM_VALS-1)/2+1).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  in_data and descending are valid.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 in_data  input  NUM_VALS*WIDTH  unsorted vector; element i occupies bits [(NUM_VALS-i)*WIDTH-1 -: WIDTH], so element 0 sits at the MSBs.
REQ-009 descending  input  1  sort-order select: 0 = ascending, 1 = descending.
REQ-010 out_valid  output  1  out_data and swap_count hold a finished result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  NUM_VALS*WIDTH  sorted vector, using the same element packing as in_data.
REQ-013 swap_count  output  CW  number of element exchanges performed for this vector.

Function
REQ-014 SHALL implement odd-even transposition sort as an FSM with states IDLE, SORT and DONE.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in DONE only while out_ready=1; it SHALL be 0 in SORT.
REQ-016 Accept (in_valid && in_ready at an edge) SHALL load in_data into the work register, latch descending, clear swap_count and the pass counter to 0, and enter SORT.
REQ-017 Each SORT edge SHALL perform exactly one pass p.
- Even p compares pairs (0,1), (2,3), and so on.
- Odd p compares pairs (1,2), (3,4), and so on.
- An unpaired last element is left unchanged.
REQ-018 A pair (j, j+1) SHALL swap only when elem[j] > elem[j+1] (ascending) or elem[j] < elem[j+1] (descending); equal elements never swap.
REQ-019 Element comparison SHALL be unsigned, over the full WIDTH.
REQ-020 swap_count SHALL increase by the number of swaps in the pass; it cannot overflow, because the maximum is NUM_VALS*(NUM_VALS-1)/2.
REQ-021 The block SHALL execute exactly NUM_VALS passes, with no early termination.
- The edge that performs pass NUM_VALS-1 enters DONE and sets out_valid=1.
- out_valid therefore rises NUM_VALS edges after the accept edge.
REQ-022 In DONE, out_data and swap_count SHALL hold stable until out_valid && out_ready at an edge.
REQ-023 On that edge: if in_valid=1, the new vector SHALL be accepted (back-to-back) and the state goes to SORT with out_valid=0; otherwise the state goes to IDLE with out_valid=0.
REQ-024 out_data SHALL continuously reflect the work register; its value is only defined while out_valid=1.
REQ-025 Changes to in_data or descending after the accept edge SHALL NOT affect the result in flight.
REQ-026 in_valid asserted during SORT SHALL be ignored and SHALL NOT be accepted.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force the state to IDLE, out_valid=0, swap_count=0, the pass counter to 0, and the work register to all-zero, so out_data=0.
REQ-028 in_ready SHALL be 1 while rst_n=0 and after release.
REQ-029 Reset asserted mid-SORT or in DONE SHALL discard the vector in flight; no out_valid pulse SHALL follow release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (NUM_VALS=8, WIDTH=4)
REQ-031 Ascending sort:
- Stimulus: elements 3,7,1,0,15,2,9,4 with descending=0 and out_ready=1.
- Response: out_valid rises 8 edges after accept; out_data = 0,1,2,3,4,7,9,15.
REQ-032 Descending sort:
- Stimulus: the same vector with descending=1.
- Response: out_data = 15,9,7,4,3,2,1,0.
REQ-033 Swap-count extremes:
- Input 0..7 ascending gives swap_count=0 and out_data unchanged.
- Input 7,6,5,4,3,2,1,0 ascending gives swap_count=28 and out_data = 0..7.
- Input all 5s gives swap_count=0.
REQ-034 Backpressure and back-to-back:
- Hold out_ready=0 for 5 cycles after out_valid: out_data stays stable and in_ready=0.
- Then raise out_ready with in_valid=1: the second vector is accepted on that same edge and its result appears 8 edges later.
REQ-035 Reset mid-sort:
- Stimulus: drop rst_n between clock edges at pass 3.
- Response: out_valid=0, out_data=0 and in_ready=1 immediately; no result appears after release.
- A fresh vector sorts correctly afterwards.
REQ-036 Random soak:
- Stimulus: 1000 random vectors with random descending and random out_ready stalls.
- Response: each result is a sorted permutation of its input, and swap_count equals the inversion count of the input.

Source files
------------

// File: rtl/sort_seq.sv
// Sequential odd-even transposition sorter: one compare/exchange pass per clock,
// NUM_VALS passes per vector, with a valid/ready handshake on both sides.
module sort_seq #(
  parameter  int NUM_VALS = 8,
  parameter  int WIDTH    = 4,
  localparam int CW       = $clog2(NUM_VALS*(NUM_VALS-1)/2+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VALS*WIDTH-1:0] in_data,
  input  logic                      descending,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_VALS*WIDTH-1:0] out_data,
  output logic [CW-1:0]             swap_count
);

  localparam int VW = NUM_VALS*WIDTH;
  localparam int PW = $clog2(NUM_VALS);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   work_q, work_d;
  logic            desc_q, desc_d;
  logic [CW-1:0]   swap_q, swap_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] elem [NUM_VALS];
  logic [WIDTH-1:0] nxt  [NUM_VALS];
  logic [VW-1:0]    pass_work;
  logic [CW-1:0]    pass_swaps;
  logic             accept;

  // One pass of the exchange network; the pairs of a pass are disjoint, so
  // every exchange reads the pre-pass values.
  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    pass_work  = '0;
    pass_swaps = '0;
    for (int i = 0; i < NUM_VALS; i++) begin
      elem[i] = work_q[(NUM_VALS-i)*WIDTH-1 -: WIDTH];
      nxt[i]  = elem[i];
    end
    for (int j = 0; j < NUM_VALS-1; j++) begin
      if (j[0] == pass_q[0]) begin
        if (desc_q ? (elem[j] < elem[j+1]) : (elem[j] > elem[j+1])) begin
          nxt[j]     = elem[j+1];
          nxt[j+1]   = elem[j];
          pass_swaps = pass_swaps + CW'(1);
        end
      end
    end
    for (int i = 0; i < NUM_VALS; i++) begin
      pass_work[(NUM_VALS-i)*WIDTH-1 -: WIDTH] = nxt[i];
    end
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    desc_d      = desc_q;
    swap_d      = swap_q;
    pass_d      = pass_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = in_data;
          desc_d  = descending;
          swap_d  = '0;
          pass_d  = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        work_d = pass_work;
        swap_d = swap_q + pass_swaps;
        pass_d = pass_q + PW'(1);
        if (pass_q == PW'(NUM_VALS-1)) begin
          pass_d      = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            work_d  = in_data;
            desc_d  = descending;
            swap_d  = '0;
            pass_d  = '0;
            state_d = SORT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: the work register is a plain register, not a RAM, so it is reset too; that is what makes out_data read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      desc_q      <= 1'b0;
      swap_q      <= '0;
      pass_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q     <= state_d;
      work_q      <= work_d;
      desc_q      <= desc_d;
      swap_q      <= swap_d;
      pass_q      <= pass_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = work_q;
  assign swap_count = swap_q;

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: a reference sort and inversion count predict
// each result when the vector is accepted; results are popped as they appear.
module tb_sort_seq;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int VW = N*W;
  localparam int CW = $clog2(N*(N-1)/2+1);

  typedef struct {
    logic [VW-1:0] data;
    int            swaps;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          descending;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [CW-1:0] swap_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  sort_seq #(.NUM_VALS(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .descending (descending),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // Reference: insertion sort plus an O(N^2) inversion count.
  function automatic exp_t model(input logic [VW-1:0] v, input logic d);
    exp_t e;
    int   a[N];
    int   key, k;
    e.swaps = 0;
    for (int i = 0; i < N; i++) a[i] = int'(v[(N-i)*W-1 -: W]);
    for (int i = 0; i < N; i++)
      for (int j = i+1; j < N; j++)
        if (d ? (a[i] < a[j]) : (a[i] > a[j])) e.swaps++;
    for (int i = 1; i < N; i++) begin
      key = a[i];
      k   = i - 1;
      while (k >= 0 && (d ? (a[k] < key) : (a[k] > key))) begin
        a[k+1] = a[k];
        k--;
      end
      a[k+1] = key;
    end
    e.data = '0;
    for (int i = 0; i < N; i++) e.data[(N-i)*W-1 -: W] = W'(a[i]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a vector until it is accepted, then scrambles the inputs.
  task automatic send(input logic [VW-1:0] v, input logic d);
    int waited = 0;
    in_data    = v;
    descending = d;
    in_valid   = 1'b1;
    #0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid   = 1'b0;
    in_data    = $urandom;
    descending = ~d;
    sb.push_back(model(v, d));
  endtask

  // Waits for out_valid, checks latency, in_ready during SORT, and the result.
  task automatic collect(input bit rand_rdy, output logic [VW-1:0] d_o,
                         output logic [CW-1:0] s_o);
    exp_t e;
    int   lat = 0;
    bool_loop: while (lat < 40) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (out_valid) break;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL ready_in_sort: in_ready=%0b at cycle %0d, required 0", in_ready, lat);
      end
    end
    d_o = out_data;
    s_o = swap_count;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
      return;
    end
    n_checks++;
    if (lat != N) begin
      n_errors++;
      $display("FAIL latency: %0d edges, required %0d", lat, N);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got result %h, required no result", out_data);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (out_data !== e.data) begin
      n_errors++;
      $display("FAIL out_data: got %h, required %h", out_data, e.data);
    end
    n_checks++;
    if (swap_count !== CW'(e.swaps)) begin
      n_errors++;
      $display("FAIL swap_count: got %0d, required %0d", swap_count, e.swaps);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain: out_valid=%0b after consume, required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    descending = 1'b0;
    out_ready  = 1'b1;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || swap_count !== '0) begin
      n_errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%h swap_count=%0d, required 1 0 0 0",
               in_ready, out_valid, out_data, swap_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
  endtask

  // Also the first accept after reset release.
  task automatic test_ascending();
    logic [VW-1:0] d;
    logic [CW-1:0] s;
    send(32'h3710_F294, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL first_accept: in_ready=%0b after first edge, required 0", in_ready);
    end
    collect(1'b0, d, s);
    n_checks++;
    if (d !== 32'h0123_479F) begin
      n_errors++;
      $display("FAIL ascending_vector: got %h, required 0123479f", d);
    end
    drain();
  endtask

  task automatic test_descending();
    logic [VW-1:0] d;
    logic [CW-1:0] s;
    send(32'h3710_F294, 1'b1);
    collect(1'b0, d, s);
    n_checks++;
    if (d !== 32'hF974_3210) begin
      n_errors++;
      $display("FAIL descending_vector: got %h, required f9743210", d);
    end
    drain();
  endtask

  task automatic test_swap_extremes();
    logic [VW-1:0] vin [3];
    logic [VW-1:0] vout[3];
    int            sw  [3];
    logic [VW-1:0] d;
    logic [CW-1:0] s;
    vin[0] = 32'h0123_4567; vout[0] = 32'h0123_4567; sw[0] = 0;
    vin[1] = 32'h7654_3210; vout[1] = 32'h0123_4567; sw[1] = 28;
    vin[2] = 32'h5555_5555; vout[2] = 32'h5555_5555; sw[2] = 0;
    for (int t = 0; t < 3; t++) begin
      send(vin[t], 1'b0);
      collect(1'b0, d, s);
      n_checks++;
      if (d !== vout[t] || s !== CW'(sw[t])) begin
        n_errors++;
        $display("FAIL extreme_%0d: got %h/%0d, required %h/%0d", t, d, s, vout[t], sw[t]);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] d, d2;
    logic [CW-1:0] s, s2;
    out_ready = 1'b0;
    send(32'h9A0C_3B18, 1'b0);
    // Held request during SORT and the stalled DONE must not be taken early.
    in_valid   = 1'b1;
    in_data    = 32'h2E64_D071;
    descending = 1'b1;
    collect(1'b0, d, s);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d || swap_count !== s || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_%0d: out_valid=%0b out_data=%h swap_count=%0d in_ready=%0b, required 1 %h %0d 0",
                 c, out_valid, out_data, swap_count, in_ready, d, s);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready: in_ready=%0b with out_ready=1 in DONE, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    sb.push_back(model(32'h2E64_D071, 1'b1));
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_accept: out_valid=%0b in_ready=%0b, required 0 0", out_valid, in_ready);
    end
    collect(1'b0, d2, s2);
    drain();
  endtask

  task automatic test_reset_mid_sort();
    logic [VW-1:0] d;
    logic [CW-1:0] s;
    int            seen = 0;
    send(32'hC3A1_7E05, 1'b0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || swap_count !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: out_valid=%0b out_data=%h in_ready=%0b swap_count=%0d, required 0 0 1 0",
               out_valid, out_data, in_ready, swap_count);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL ghost_result: out_valid high %0d cycles after reset, required 0", seen);
    end
    send(32'hC3A1_7E05, 1'b1);
    collect(1'b0, d, s);
    drain();
  endtask

  task automatic test_random_soak();
    logic [VW-1:0] d;
    logic [CW-1:0] s;
    int            stall;
    for (int v = 0; v < 1000; v++) begin
      send(VW'($urandom), 1'($urandom_range(0, 1)));
      collect(1'b1, d, s);
      out_ready = 1'b0;
      stall = $urandom_range(0, 3);
      for (int c = 0; c < stall; c++) begin
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== d || swap_count !== s) begin
          n_errors++;
          $display("FAIL soak_stall v%0d: out_valid=%0b out_data=%h swap_count=%0d, required 1 %h %0d",
                   v, out_valid, out_data, swap_count, d, s);
        end
      end
      out_ready = 1'b1;
      // Otherwise leave DONE with out_ready=1 so the next send is back-to-back.
      if ($urandom_range(0, 1) == 0 || v == 999) drain();
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_swap_extremes();
    test_back_to_back();
    test_reset_mid_sort();
    test_random_soak();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: %0d expected results never produced, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
